neighbor_index_gen_v3: RTL and testbench

Parametrised successor to the single/pair neighbour index generator. From a captured reference assignment `x0` of J variables, each over alphabet 0..A-1, it enumerates every candidate differing from `x0` in one variable (single phase) and/or two variables (pair phase). Variable `J_index` and variables at or above a runtime `j_active` are excluded. Each candidate is emitted as multiplier/divisor row and column indices over a valid/ready stream with backpressure, last-beat marking and a beat counter; the output feeds the candidate metric accumulator.

---
 rtl/neighbor_index_gen_v3_if.sv | 32 +++
 rtl/neighbor_index_gen_v3.sv | 180 ++++++++++++++++++
 tb/tb_neighbor_index_gen_v3.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_index_gen_v3_if.sv
// neighbor_index_gen_v3_if: candidate beat stream between the neighbour index generator and its consumer.
// Signals: out_valid/out_ready handshake, out_last final-beat flag, out_phase (1 single, 2 pair),
// row1/row2 changed variable indices, col1/col2 new symbols, div_col1/div_col2 reference symbols.
// Modports: master (generator side), slave (consumer side).
interface neighbor_index_gen_v3_if #(
    parameter int J = 14,
    parameter int A = 2
);
    localparam int AWIDTH  = $clog2(A) + 1;
    localparam int J_WIDTH = $clog2(J) + 1;

    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [1:0]         out_phase;
    logic [J_WIDTH-1:0] row1;
    logic [J_WIDTH-1:0] row2;
    logic [AWIDTH-1:0]  col1;
    logic [AWIDTH-1:0]  col2;
    logic [AWIDTH-1:0]  div_col1;
    logic [AWIDTH-1:0]  div_col2;

    modport master (
        output out_valid, out_last, out_phase, row1, row2, col1, col2, div_col1, div_col2,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_last, out_phase, row1, row2, col1, col2, div_col1, div_col2,
        output out_ready
    );
endinterface

// File: rtl/neighbor_index_gen_v3.sv
// neighbor_index_gen_v3: enumerates every single- and pair-variable neighbour of a captured
// reference assignment x0 and streams them as multiplier/divisor row/column index beats.
// Ports: clk; rst_n (synchronous, active-low); x_initial/x_initial_tvalid capture x0 while not busy;
// start/mode/J_index/j_active launch an enumeration (snapshotted at start); abort cancels it;
// out_if (master) carries the candidate beats; busy, done (one-cycle pulse) and cand_count
// (handshakes since the last accepted start) report progress.
module neighbor_index_gen_v3 #(
    parameter int J = 14,
    parameter int A = 2,
    localparam int AWIDTH  = $clog2(A) + 1,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int CNT_W   = 2 * J_WIDTH + 2 * AWIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [J*AWIDTH-1:0]     x_initial,
    input  logic                    x_initial_tvalid,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [J_WIDTH-1:0]      J_index,
    input  logic [J_WIDTH-1:0]      j_active,
    input  logic                    abort,
    neighbor_index_gen_v3_if.master out_if,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        cand_count
);
    // One extra bit so stepping past the last variable (j+2) never wraps.
    localparam int JX = J_WIDTH + 1;
    localparam int AX = AWIDTH + 1;
    localparam logic [AWIDTH-1:0] DMAX = AWIDTH'(A - 1);
    localparam logic [AWIDTH-1:0] ONE  = AWIDTH'(1);

    typedef enum logic [1:0] {IDLE, SINGLE, PAIR, DONE} state_t;

    state_t              state_q, state_d;
    logic [J*AWIDTH-1:0] x0_q;
    logic [J_WIDTH-1:0]  ji_q, ja_q, j1_q, j2_q;
    logic [1:0]          mode_q;
    logic [AWIDTH-1:0]   d1_q, d2_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [JX-1:0]       first_in, second_in, ja_in, first_q, second_q, jaq, j1n, j2n;
    logic                single_start, pair_start, single_end, pair_end, pairs_follow;
    logic                d1_max, d2_max, valid, hs, accept;
    logic [AWIDTH-1:0]   s1, s2;

    // Next eligible index after j: only one variable can be excluded, so skip at most one.
    function automatic logic [JX-1:0] nxt(input logic [JX-1:0] j, input logic [J_WIDTH-1:0] ex);
        return (j + JX'(1) == JX'(ex)) ? j + JX'(2) : j + JX'(1);
    endfunction

    function automatic logic [AWIDTH-1:0] sym(input logic [J*AWIDTH-1:0] x, input logic [J_WIDTH-1:0] j);
        logic [AWIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < J; i++)
            if (j == J_WIDTH'(i)) s = x[i*AWIDTH +: AWIDTH];
        return s;
    endfunction

    // (s + d) mod A in one extra bit so the sum cannot overflow for any A.
    function automatic logic [AWIDTH-1:0] inc(input logic [AWIDTH-1:0] s, input logic [AWIDTH-1:0] d);
        logic [AX-1:0] t;
        t = {1'b0, s} + {1'b0, d};
        return AWIDTH'(t >= AX'(A) ? t - AX'(A) : t);
    endfunction

    always_comb begin
        first_in     = (J_index == '0) ? JX'(1) : JX'(0);
        second_in    = nxt(first_in, J_index);
        ja_in        = JX'(j_active);
        // n >= 1 iff the first eligible index is active; n >= 2 likewise for the second.
        single_start = (mode == 2'd1 || mode == 2'd2) && first_in < ja_in;
        pair_start   = mode[1] && second_in < ja_in;
        first_q      = (ji_q == '0) ? JX'(1) : JX'(0);
        second_q     = nxt(first_q, ji_q);
        jaq          = JX'(ja_q);
        j1n          = nxt({1'b0, j1_q}, ji_q);
        j2n          = nxt({1'b0, j2_q}, ji_q);
        d1_max       = d1_q == DMAX;
        d2_max       = d2_q == DMAX;
        single_end   = d1_max && j1n >= jaq;
        // Final pair: j2 is the last eligible index and j1 sits directly before it.
        pair_end     = d1_max && d2_max && j2n >= jaq && j1n == {1'b0, j2_q};
        pairs_follow = mode_q == 2'd2 && second_q < jaq;
        valid        = state_q == SINGLE || state_q == PAIR;
        hs           = valid && out_if.out_ready && !abort;
        accept       = !valid && start && !abort;
        s1           = sym(x0_q, j1_q);
        s2           = sym(x0_q, j2_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = !start ? IDLE : single_start ? SINGLE : pair_start ? PAIR : DONE;
            SINGLE:     if (hs && single_end) state_d = pairs_follow ? PAIR : DONE;
            PAIR:       if (hs && pair_end) state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x0_q   <= '0;
            ji_q   <= '0;
            ja_q   <= '0;
            mode_q <= '0;
            j1_q   <= '0;
            j2_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (!valid && x_initial_tvalid) x0_q <= x_initial;
            if (accept) begin
                ji_q   <= J_index;
                ja_q   <= j_active;
                mode_q <= mode;
                cnt_q  <= '0;
                j1_q   <= J_WIDTH'(first_in);
                j2_q   <= J_WIDTH'(second_in);
                d1_q   <= ONE;
                d2_q   <= ONE;
            end else if (hs) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (state_q == SINGLE) begin
                    if (single_end) begin
                        // Preload the first pair so the pair phase starts without a bubble.
                        j1_q <= J_WIDTH'(first_q);
                        j2_q <= J_WIDTH'(second_q);
                        d1_q <= ONE;
                        d2_q <= ONE;
                    end else if (d1_max) begin
                        j1_q <= J_WIDTH'(j1n);
                        d1_q <= ONE;
                    end else begin
                        d1_q <= d1_q + ONE;
                    end
                end else begin
                    d2_q <= d2_max ? ONE : d2_q + ONE;
                    if (d2_max) begin
                        d1_q <= d1_max ? ONE : d1_q + ONE;
                        if (d1_max) begin
                            if (j2n < jaq) begin
                                j2_q <= J_WIDTH'(j2n);
                            end else begin
                                j1_q <= J_WIDTH'(j1n);
                                j2_q <= J_WIDTH'(nxt(j1n, ji_q));
                            end
                        end
                    end
                end
            end
        end
    end

    // Beat fields are decoded from registered position and x0, so they hold during stalls.
    always_comb begin
        out_if.out_valid = valid;
        out_if.out_phase = state_q == SINGLE ? 2'd1 : state_q == PAIR ? 2'd2 : 2'd0;
        out_if.out_last  = state_q == SINGLE ? single_end && !pairs_follow : state_q == PAIR && pair_end;
        out_if.row1      = valid ? j1_q : '0;
        out_if.col1      = valid ? inc(s1, d1_q) : '0;
        out_if.div_col1  = valid ? s1 : '0;
        out_if.row2      = state_q == PAIR ? j2_q : '0;
        out_if.col2      = state_q == PAIR ? inc(s2, d2_q) : '0;
        out_if.div_col2  = state_q == PAIR ? s2 : '0;
        busy             = valid;
        done             = state_q == DONE;
    end

    assign cand_count = cnt_q;
endmodule

// File: tb/tb_neighbor_index_gen_v3.sv
// tb_neighbor_index_gen_v3: scoreboard bench for neighbor_index_gen_v3 (J=4/A=3 and J=4/A=2 instances).
module tb_neighbor_index_gen_v3;
    typedef struct packed {
        logic [1:0] ph;
        logic       last;
        logic [2:0] r1, r2, c1, c2, d1, d2;
    } beat_t;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic [11:0] xa;
    logic        xva, sta, aba, busya, donea;
    logic [1:0]  modea;
    logic [2:0]  jia, jaa;
    logic [11:0] cnta;

    logic [7:0]  xb;
    logic        xvb, stb, abb, busyb, doneb;
    logic [1:0]  modeb;
    logic [2:0]  jib, jab;
    logic [9:0]  cntb;

    neighbor_index_gen_v3_if #(.J(4), .A(3)) ia ();
    neighbor_index_gen_v3_if #(.J(4), .A(2)) ib ();

    neighbor_index_gen_v3 #(.J(4), .A(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .x_initial(xa), .x_initial_tvalid(xva), .start(sta),
        .mode(modea), .J_index(jia), .j_active(jaa), .abort(aba), .out_if(ia),
        .busy(busya), .done(donea), .cand_count(cnta)
    );

    neighbor_index_gen_v3 #(.J(4), .A(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .x_initial(xb), .x_initial_tvalid(xvb), .start(stb),
        .mode(modeb), .J_index(jib), .j_active(jab), .abort(abb), .out_if(ib),
        .busy(busyb), .done(doneb), .cand_count(cntb)
    );

    int    n_checks = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    x_t1 [4] = '{0, 1, 2, 0};
    int    x_t3 [4] = '{1, 0, 0, 0};

    function automatic beat_t obs_a();
        beat_t b;
        b.ph = ia.out_phase; b.last = ia.out_last;
        b.r1 = ia.row1; b.c1 = ia.col1; b.d1 = ia.div_col1;
        b.r2 = ia.row2; b.c2 = ia.col2; b.d2 = ia.div_col2;
        return b;
    endfunction

    function automatic beat_t obs_b();
        beat_t b;
        b.ph = ib.out_phase; b.last = ib.out_last;
        b.r1 = ib.row1; b.c1 = {1'b0, ib.col1}; b.d1 = {1'b0, ib.div_col1};
        b.r2 = ib.row2; b.c2 = {1'b0, ib.col2}; b.d2 = {1'b0, ib.div_col2};
        return b;
    endfunction

    // Reference enumeration written straight from the ordering rules.
    task automatic push_exp(input int x0 [4], input int a, input int ji, input int ja, input int md);
        int    e[$];
        beat_t q[$];
        beat_t b;
        for (int j = 0; j < ja; j++) if (j != ji) e.push_back(j);
        if (md == 1 || md == 2)
            foreach (e[k])
                for (int d = 1; d < a; d++) begin
                    b = '0; b.ph = 2'd1;
                    b.r1 = 3'(e[k]); b.c1 = 3'((x0[e[k]] + d) % a); b.d1 = 3'(x0[e[k]]);
                    q.push_back(b);
                end
        if (md == 2 || md == 3)
            for (int m = 0; m < e.size(); m++)
                for (int n = m + 1; n < e.size(); n++)
                    for (int p = 1; p < a; p++)
                        for (int s = 1; s < a; s++) begin
                            b = '0; b.ph = 2'd2;
                            b.r1 = 3'(e[m]); b.c1 = 3'((x0[e[m]] + p) % a); b.d1 = 3'(x0[e[m]]);
                            b.r2 = 3'(e[n]); b.c2 = 3'((x0[e[n]] + s) % a); b.d2 = 3'(x0[e[n]]);
                            q.push_back(b);
                        end
        if (q.size() > 0) q[q.size() - 1].last = 1'b1;
        foreach (q[k]) exp_q.push_back(q[k]);
    endtask

    // Entered at a negedge; returns at the negedge of the cycle after the accepted start.
    task automatic kick_a(input int x0 [4], input int ji, input int ja, input int md);
        for (int i = 0; i < 4; i++) xa[i*3 +: 3] = 3'(x0[i]);
        jia = 3'(ji); jaa = 3'(ja); modea = 2'(md); xva = 1; sta = 1;
        push_exp(x0, 3, ji, ja, md);
        @(negedge clk);
        xva = 0; sta = 0;
    endtask

    // Drains dut_a against the scoreboard; stops early (ready low) once stop_after beats are taken.
    task automatic run_stream(input int pct, input int stop_after, input bit poke, output int got);
        beat_t o, e, held;
        bit    stalled = 0, poked = 0;
        int    total;
        total = exp_q.size();
        got = 0;
        held = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            sta = 0; xva = 0;
            if (poke && got == 3 && !poked) begin
                sta = 1; xva = 1; xa = '1; modea = 2'd0; jaa = 3'd0; poked = 1;
            end
            o = obs_a();
            n_checks++;
            if (donea !== 1'b0 || ia.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_valid beat %0d: valid=%b done=%b, required valid=1 done=0", got, ia.out_valid, donea);
                ia.out_ready = 0; sta = 0; xva = 0;
                return;
            end
            if (stalled) begin
                n_checks++;
                if (o !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold beat %0d: got %h, required %h", got, o, held);
                end
            end
            if (got == stop_after) begin
                ia.out_ready = 0; sta = 0; xva = 0;
                return;
            end
            ia.out_ready = ($urandom_range(0, 99) < pct);
            stalled = !ia.out_ready;
            held = o;
            if (ia.out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL beat %0d: got %h, required %h", got + 1, o, e);
                end
                got++;
            end
            @(negedge clk);
            if (got == total) begin
                ia.out_ready = 0; sta = 0; xva = 0;
                n_checks++;
                if (donea !== 1'b1 || ia.out_valid !== 1'b0 || busya !== 1'b0) begin
                    n_fail++;
                    $display("FAIL completion: done=%b valid=%b busy=%b, required 1 0 0", donea, ia.out_valid, busya);
                end
                n_checks++;
                if (cnta !== 12'(total)) begin
                    n_fail++;
                    $display("FAIL cand_count: got %0d, required %0d", cnta, total);
                end
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL stream_timeout: got %0d beats, required %0d", got, total);
        ia.out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ia.out_valid, ia.out_last, ia.out_phase, busya, donea} !== 5'b0 || cnta !== 12'd0 || obs_a() !== beat_t'(0)) begin
            n_fail++;
            $display("FAIL reset_a: valid=%b busy=%b done=%b cnt=%0d beat=%h, required all 0", ia.out_valid, busya, donea, cnta, obs_a());
        end
        n_checks++;
        if ({ib.out_valid, busyb, doneb} !== 3'b0 || cntb !== 10'd0 || obs_b() !== beat_t'(0)) begin
            n_fail++;
            $display("FAIL reset_b: valid=%b busy=%b done=%b cnt=%0d, required all 0", ib.out_valid, busyb, doneb, cntb);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_full_enumeration();
        int got;
        kick_a(x_t1, 1, 4, 2);
        run_stream(100, 1000, 0, got);
        n_checks++;
        if (got !== 18) begin
            n_fail++;
            $display("FAIL full_beats: got %0d, required 18", got);
        end
    endtask

    // Entered in the done cycle of the previous run, so the first start also covers start-in-E+1.
    task automatic test_empty();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) kick_a(x_t1, 0, 1, 2);
            else        kick_a(x_t1, 1, 4, 0);
            n_checks++;
            if (donea !== 1'b1 || ia.out_valid !== 1'b0 || busya !== 1'b0 || cnta !== 12'd0) begin
                n_fail++;
                $display("FAIL empty_%0d: done=%b valid=%b busy=%b cnt=%0d, required 1 0 0 0", k, donea, ia.out_valid, busya, cnta);
            end
            @(negedge clk);
            n_checks++;
            if (donea !== 1'b0 || ia.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_pulse_%0d: done=%b valid=%b, required 0 0", k, donea, ia.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        kick_a(x_t1, 1, 4, 2);
        run_stream(50, 1000, 0, got);
        n_checks++;
        if (got !== 18) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d, required 18", got);
        end
        @(negedge clk);
    endtask

    task automatic test_pairs_only();
        beat_t o, e;
        for (int i = 0; i < 4; i++) xb[i*2 +: 2] = 2'(x_t3[i]);
        jib = 3'd3; jab = 3'd2; modeb = 2'd3; xvb = 1; stb = 1; ib.out_ready = 1;
        push_exp(x_t3, 2, 3, 2, 3);
        @(negedge clk);
        xvb = 0; stb = 0;
        o = obs_b();
        e = exp_q.pop_front();
        n_checks++;
        if (ib.out_valid !== 1'b1 || o !== e) begin
            n_fail++;
            $display("FAIL pairs_only_beat: valid=%b got %h, required valid=1 %h", ib.out_valid, o, e);
        end
        @(negedge clk);
        ib.out_ready = 0;
        n_checks++;
        if (doneb !== 1'b1 || ib.out_valid !== 1'b0 || cntb !== 10'd1) begin
            n_fail++;
            $display("FAIL pairs_only_done: done=%b valid=%b cnt=%0d, required 1 0 1", doneb, ib.out_valid, cntb);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int got;
        kick_a(x_t1, 1, 4, 2);
        run_stream(100, 5, 0, got);
        aba = 1;
        @(negedge clk);
        aba = 0;
        n_checks++;
        if (ia.out_valid !== 1'b0 || busya !== 1'b0 || donea !== 1'b0 || ia.out_last !== 1'b0 || cnta !== 12'd5) begin
            n_fail++;
            $display("FAIL abort: valid=%b busy=%b done=%b last=%b cnt=%0d, required 0 0 0 0 5", ia.out_valid, busya, donea, ia.out_last, cnta);
        end
        @(negedge clk);
        n_checks++;
        if (donea !== 1'b0 || cnta !== 12'd5) begin
            n_fail++;
            $display("FAIL abort_after: done=%b cnt=%0d, required 0 5", donea, cnta);
        end
        exp_q.delete();
    endtask

    task automatic test_ignored_inputs();
        int got;
        kick_a(x_t1, 1, 4, 2);
        run_stream(100, 1000, 1, got);
        n_checks++;
        if (got !== 18) begin
            n_fail++;
            $display("FAIL ignored_beats: got %0d, required 18", got);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int got;
        kick_a(x_t1, 1, 4, 2);
        run_stream(100, 9, 0, got);
        n_checks++;
        if (ia.out_phase !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_pair_phase: got %0d, required 2", ia.out_phase);
        end
        rst_n = 0;
        @(negedge clk);
        n_checks++;
        if ({ia.out_valid, busya, donea} !== 3'b0 || cnta !== 12'd0 || obs_a() !== beat_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_run: valid=%b busy=%b done=%b cnt=%0d beat=%h, required all 0", ia.out_valid, busya, donea, cnta, obs_a());
        end
        rst_n = 1;
        exp_q.delete();
        @(negedge clk);
        kick_a(x_t1, 1, 4, 2);
        run_stream(100, 1000, 0, got);
        n_checks++;
        if (got !== 18) begin
            n_fail++;
            $display("FAIL restart_beats: got %0d, required 18", got);
        end
        @(negedge clk);
    endtask

    initial begin
        xa = '0; xva = 0; sta = 0; aba = 0; modea = '0; jia = '0; jaa = '0; ia.out_ready = 0;
        xb = '0; xvb = 0; stb = 0; abb = 0; modeb = '0; jib = '0; jab = '0; ib.out_ready = 0;
        test_reset();
        test_full_enumeration();
        test_empty();
        test_backpressure();
        test_pairs_only();
        test_abort();
        test_ignored_inputs();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
